// File: rtl/adc_scan_avg.sv
// Round-robin ADC channel scanner with a per-channel boxcar average of 2^AVG_LOG2 samples.
// Completed scans are committed atomically to avg_out for the AXI4-Lite register bank.
`timescale 1ns/1ps
module adc_scan_avg #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       enable,
  input  logic                       err_clr,
  output logic                       adc_req,
  output logic [2:0]                 adc_ch,
  input  logic                       adc_ack,
  input  logic [SAMPLE_W-1:0]        adc_data,
  output logic [NUM_CH*SAMPLE_W-1:0] avg_out,
  output logic                       avg_valid,
  output logic [31:0]                scan_cnt,
  output logic                       timeout_err,
  output logic                       busy
);

  localparam int ACC_W  = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  N_SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [2:0]        LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_ACC, ST_NEXT} state_t;

  state_t                     state;
  logic [2:0]                 ch;
  logic [CNT_W-1:0]           smp_cnt;
  logic [ACC_W-1:0]           acc;
  logic [WAIT_W-1:0]          wait_cnt;
  logic [SAMPLE_W-1:0]        sample;
  logic [NUM_CH*SAMPLE_W-1:0] shadow;

  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_sample;

  assign acc_sum     = acc + ACC_W'(sample);
  assign cnt_inc     = smp_cnt + CNT_W'(1);
  assign last_sample = (cnt_inc == N_SAMPLES);
  assign busy        = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      ch          <= '0;
      smp_cnt     <= '0;
      acc         <= '0;
      wait_cnt    <= '0;
      adc_req     <= 1'b0;
      adc_ch      <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      scan_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      // A timeout set later in this block overrides the clear: set wins.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable) begin
            ch      <= '0;
            smp_cnt <= '0;
            acc     <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          adc_req  <= 1'b1;
          adc_ch   <= ch;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (adc_ack) begin
            adc_req <= 1'b0;
            state   <= ST_ACC;
          end else if (wait_cnt == WAIT_LAST) begin
            adc_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_REQ;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_ACC: begin
          acc     <= acc_sum;
          smp_cnt <= cnt_inc;
          state   <= last_sample ? ST_NEXT : ST_REQ;
        end
        ST_NEXT: begin
          acc     <= '0;
          smp_cnt <= '0;
          if (ch < LAST_CH) begin
            ch    <= ch + 3'd1;
            state <= ST_REQ;
          end else begin
            avg_out   <= shadow;
            avg_valid <= 1'b1;
            scan_cnt  <= scan_cnt + 32'd1;
            ch        <= '0;
            state     <= enable ? ST_REQ : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: sample and shadow are rewritten before they are ever consumed, so they carry no reset.
  always_ff @(posedge ACLK) begin
    if (state == ST_WAIT && adc_ack) sample <= adc_data;
    if (state == ST_ACC && last_sample)
      shadow[ch*SAMPLE_W +: SAMPLE_W] <= acc_sum[ACC_W-1:AVG_LOG2];
  end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Scoreboard bench for adc_scan_avg: a behavioural ADC front end answers requests from a
// per-channel data table; a monitor pops hand-computed scan results on every avg_valid.
`timescale 1ns/1ps
module tb_adc_scan_avg;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 12;
  localparam int AVG_LOG2 = 3;
  localparam int TIMEOUT  = 255;
  localparam int AVG_W    = NUM_CH * SAMPLE_W;

  logic                ACLK = 1'b0;
  logic                ARESETN = 1'b0;
  logic                enable = 1'b0;
  logic                err_clr = 1'b0;
  logic                adc_ack;
  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_req;
  logic [2:0]          adc_ch;
  logic [AVG_W-1:0]    avg_out;
  logic                avg_valid;
  logic [31:0]         scan_cnt;
  logic                timeout_err;
  logic                busy;

  adc_scan_avg #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .err_clr(err_clr),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .avg_out(avg_out), .avg_valid(avg_valid), .scan_cnt(scan_cnt),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [AVG_W-1:0] avg;
    logic [31:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cnt = 0;
  logic [AVG_W-1:0] hold_avg = '0;

  logic [SAMPLE_W-1:0] data_tab [NUM_CH][8];
  logic [2:0]          idx [NUM_CH];
  int                  ack_delay = 2;
  int                  wait_ctr = 0;
  logic                stall_en = 1'b0;
  logic [2:0]          stall_ch = '0;
  logic                late_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ADC front end: acks ack_delay cycles into a request, or withholds the stalled sample.
  always @(negedge ACLK) begin
    adc_ack = 1'b0;
    if (!ARESETN) begin
      wait_ctr = 0;
      for (int c = 0; c < NUM_CH; c++) idx[c] = '0;
    end
    if (late_ack) begin
      adc_ack  = 1'b1;
      adc_data = 12'hABC;
    end else if (ARESETN && adc_req) begin
      if (stall_en && adc_ch == stall_ch && idx[adc_ch[1:0]] == 3'd0) begin
        wait_ctr = 0;
      end else if (wait_ctr >= ack_delay) begin
        adc_ack  = 1'b1;
        adc_data = data_tab[adc_ch[1:0]][idx[adc_ch[1:0]]];
        idx[adc_ch[1:0]] = idx[adc_ch[1:0]] + 3'd1;
        wait_ctr = 0;
      end else begin
        wait_ctr++;
      end
    end else begin
      wait_ctr = 0;
    end
  end

  // Monitor: every avg_valid must match the oldest expected scan; avg_out holds otherwise.
  always @(negedge ACLK) begin
    if (!ARESETN) hold_avg = '0;
    if (avg_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL avg_valid_unexpected: got commit avg_out=%h, expected none", avg_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("avg_out", 64'(avg_out), 64'(mon_e.avg));
        check("scan_cnt", 64'(scan_cnt), 64'(mon_e.cnt));
        hold_avg = mon_e.avg;
      end
    end else begin
      check("avg_out_hold", 64'(avg_out), 64'(hold_avg));
    end
  end

  task automatic expect_scan(input logic [AVG_W-1:0] avg, input logic [31:0] cnt);
    exp_t e;
    e.avg = avg;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic start_scan(input bit keep);
    @(negedge ACLK);
    enable = 1'b1;
    @(negedge ACLK);
    check("start_busy", 64'(busy), 64'(1));
    check("start_req_not_yet", 64'(adc_req), 64'(0));
    if (!keep) enable = 1'b0;
    @(negedge ACLK);
    check("start_req_high", 64'(adc_req), 64'(1));
    check("start_ch0", 64'(adc_ch), 64'(0));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge ACLK);
      n++;
    end
    check({name, "_idle"}, 64'(busy), 64'(0));
    @(negedge ACLK);
  endtask

  task automatic wait_req_ch(input logic [2:0] c, input string name);
    int n = 0;
    while (!(adc_req && adc_ch == c) && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    check({name, "_req_seen"}, 64'(adc_req && adc_ch == c), 64'(1));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!avg_valid && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    check({name, "_valid_seen"}, 64'(avg_valid), 64'(1));
  endtask

  // Withholds the first sample of channel c until the DUT gives up; optionally clears
  // timeout_err in the very cycle the timeout fires.
  task automatic stall_once(input logic [2:0] c, input bit clr_same);
    int hi;
    stall_ch = c;
    stall_en = 1'b1;
    wait_req_ch(c, "stall");
    hi = 1;
    while (hi < TIMEOUT) begin
      @(negedge ACLK);
      if (!adc_req) break;
      hi++;
    end
    if (clr_same) err_clr = 1'b1;
    @(negedge ACLK);
    err_clr  = 1'b0;
    stall_en = 1'b0;
    check("timeout_req_high_cycles", 64'(hi), 64'(TIMEOUT));
    check("timeout_req_dropped", 64'(adc_req), 64'(0));
    check("timeout_err_set", 64'(timeout_err), 64'(1));
  endtask

  initial begin
    int v0;

    // Reset and idle
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      check("reset_req", 64'(adc_req), 64'(0));
    end
    check("reset_ch", 64'(adc_ch), 64'(0));
    check("reset_avg_out", 64'(avg_out), 64'(0));
    check("reset_avg_valid", 64'(avg_valid), 64'(0));
    check("reset_scan_cnt", 64'(scan_cnt), 64'(0));
    check("reset_timeout_err", 64'(timeout_err), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    #2 ARESETN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      check("idle_req", 64'(adc_req), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end

    // Constant input per channel
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < NUM_CH; c++) data_tab[c][i] = 12'h100 * 12'(c + 1);
    expect_scan(48'h400_300_200_100, 32'd1);
    v0 = valid_cnt;
    start_scan(1'b0);
    wait_idle("const");
    check("const_valid_pulses", 64'(valid_cnt - v0), 64'(1));

    // Truncation and full-scale width: ch0 32753>>3 = 0xFFE, ch1 7>>3 = 0, ch3 92>>3 = 11
    for (int i = 0; i < 8; i++) begin
      data_tab[0][i] = (i == 7) ? 12'hFF8 : 12'hFFF;
      data_tab[1][i] = (i == 7) ? 12'h000 : 12'h001;
      data_tab[2][i] = 12'hFFF;
      data_tab[3][i] = 12'h008 + 12'(i);
    end
    expect_scan(48'h00B_FFF_000_FFE, 32'd2);
    start_scan(1'b0);
    wait_idle("trunc");

    // Timeout on ch2, clear alone, then clear coincident with a timeout on ch3
    for (int i = 0; i < 8; i++) begin
      data_tab[0][i] = 12'h123;
      data_tab[1][i] = (i % 2 == 0) ? 12'h800 : 12'h000;
      data_tab[2][i] = 12'h010 + 12'(i);
      data_tab[3][i] = 12'hA5A;
    end
    expect_scan(48'hA5A_013_400_123, 32'd3);
    start_scan(1'b0);
    stall_once(3'd2, 1'b0);
    @(negedge ACLK);
    err_clr = 1'b1;
    @(negedge ACLK);
    err_clr = 1'b0;
    check("err_clr_alone", 64'(timeout_err), 64'(0));
    stall_once(3'd3, 1'b1);
    wait_idle("timeout");
    check("timeout_err_sticky", 64'(timeout_err), 64'(1));

    // Counter wrap over two back-to-back scans, enable dropped during channel 1 of the second
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < NUM_CH; c++) data_tab[c][i] = 12'h0F0 + 12'(c);
    @(negedge ACLK);
    #2 force dut.scan_cnt = 32'hFFFF_FFFF;
    #1 release dut.scan_cnt;
    @(negedge ACLK);
    check("forced_scan_cnt", 64'(scan_cnt), 64'hFFFF_FFFF);
    expect_scan(48'h0F3_0F2_0F1_0F0, 32'd0);
    expect_scan(48'h0F3_0F2_0F1_0F0, 32'd1);
    v0 = valid_cnt;
    start_scan(1'b1);
    wait_valid("wrap");
    @(negedge ACLK);
    wait_req_ch(3'd1, "enable_drop");
    enable = 1'b0;
    wait_idle("enable_drop");
    check("enable_drop_valid_pulses", 64'(valid_cnt - v0), 64'(2));
    check("enable_drop_req", 64'(adc_req), 64'(0));

    // Reset while waiting on channel 3, late ack afterwards, then a clean scan
    for (int i = 0; i < 8; i++) begin
      data_tab[0][i] = 12'h001;
      data_tab[1][i] = 12'h7FF;
      data_tab[2][i] = 12'h100 * 12'(i);
      data_tab[3][i] = 12'hC00;
    end
    start_scan(1'b0);
    wait_req_ch(3'd3, "mid_reset");
    #2 ARESETN = 1'b0;
    late_ack = 1'b1;
    #1;
    check("mid_reset_req", 64'(adc_req), 64'(0));
    check("mid_reset_avg_out", 64'(avg_out), 64'(0));
    check("mid_reset_scan_cnt", 64'(scan_cnt), 64'(0));
    check("mid_reset_timeout_err", 64'(timeout_err), 64'(0));
    check("mid_reset_busy", 64'(busy), 64'(0));
    check("mid_reset_avg_valid", 64'(avg_valid), 64'(0));
    @(negedge ACLK);
    @(negedge ACLK);
    #2 ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("late_ack_req", 64'(adc_req), 64'(0));
      check("late_ack_busy", 64'(busy), 64'(0));
    end
    late_ack = 1'b0;
    expect_scan(48'hC00_380_7FF_001, 32'd1);
    start_scan(1'b0);
    wait_idle("post_reset");

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
